// File: rtl/weight_fetch_arb.sv
// Two-requester round-robin burst fetcher: streams bytes from a synchronous
// weight ROM through a 2-entry output FIFO with valid/ready backpressure.
module weight_fetch_arb #(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [2*AW-1:0]      req_base_i,
    input  logic [2*LEN_W-1:0]   req_len_i,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [7:0]           rom_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [7:0]           out_data_o,
    output logic                 out_id_o,
    output logic                 out_last_o,
    output logic [1:0]           done_o,
    output logic                 busy_o
);

    typedef enum logic {IDLE, FETCH} state_t;

    typedef struct packed {
        logic       last;
        logic       id;
        logic [7:0] data;
    } beat_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               inflight_q, inflight_d;
    logic               infl_last_q, infl_last_d;
    beat_t [1:0]        fifo_q, fifo_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         zdone_q, zdone_d;

    logic               gnt_id;
    logic               accept;
    logic               issue;
    logic               out_hs;
    logic [AW-1:0]      sel_base;
    logic [LEN_W-1:0]   sel_len;
    beat_t              head;

    assign head        = fifo_q[rd_ptr_q];
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head.data;
    assign out_id_o    = head.id;
    assign out_last_o  = head.last;
    assign out_hs      = out_valid_o & out_ready_i;
    assign busy_o      = (state_q == FETCH);
    assign rom_addr_o  = addr_q;

    // Priority pointer wins if it is asking, otherwise the other requester.
    assign gnt_id   = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;
    assign sel_base = gnt_id ? req_base_i[AW +: AW] : req_base_i[0 +: AW];
    assign sel_len  = gnt_id ? req_len_i[LEN_W +: LEN_W] : req_len_i[0 +: LEN_W];

    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && (|req_valid_i) && !rst_i)
            req_ready_o = 2'b01 << gnt_id;
    end

    assign accept = |(req_valid_i & req_ready_o);

    // Buffered plus in-flight bytes never exceed the FIFO depth, unless a
    // byte leaves this cycle and frees a slot.
    assign issue = (state_q == FETCH) && (rem_q != '0) &&
                   ((cnt_q + {1'b0, inflight_q} < 2'd2) || out_hs);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        zdone_d     = 2'b00;

        if (accept) begin
            ptr_d  = ~gnt_id;
            id_d   = gnt_id;
            addr_d = sel_base;
            rem_d  = sel_len;
            if (sel_len != '0)
                state_d = FETCH;
            else
                zdone_d = 2'b01 << gnt_id;
        end

        if (issue) begin
            addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            rem_d       = rem_q - 1'b1;
            inflight_d  = 1'b1;
            infl_last_d = (rem_q == LEN_W'(1));
        end

        if (inflight_q) begin
            fifo_d[wr_ptr_q] = '{last: infl_last_q, id: id_q, data: rom_data_i};
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (out_hs) begin
            rd_ptr_d = ~rd_ptr_q;
            if (head.last)
                state_d = IDLE;
        end

        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, out_hs};
    end

    always_comb begin
        done_o = zdone_q;
        if (out_hs && head.last)
            done_o = done_o | (2'b01 << head.id);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            zdone_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            zdone_q     <= zdone_d;
        end
    end

endmodule

// File: tb/tb_weight_fetch_arb.sv
// Bench for weight_fetch_arb: scenario tasks plus a stream scoreboard that
// expands each accepted request into its expected byte sequence.
module tb_weight_fetch_arb;

    localparam int DEPTH = 1024;
    localparam int LEN_W = 16;
    localparam int AW    = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_ready;
    logic [2*AW-1:0]    req_base = '0;
    logic [2*LEN_W-1:0] req_len = '0;
    logic [AW-1:0]      rom_addr;
    logic [7:0]         rom_data = 8'h00;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_data;
    logic               out_id;
    logic               out_last;
    logic [1:0]         done;
    logic               busy;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem [DEPTH];

    typedef struct packed {
        logic       id;
        logic       last;
        logic [7:0] data;
    } exp_t;

    weight_fetch_arb #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_base_i(req_base), .req_len_i(req_len),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_id_o(out_id), .out_last_o(out_last),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Scoreboard: every accepted request becomes len expected beats.
    task automatic mon_loop();
        exp_t q[$];
        exp_t e;
        logic [1:0] zpend, exp_done, acc;
        logic pv, pr, pl, pi;
        logic [7:0] pd;
        int aid, alen, abase;
        zpend = 2'b00; pv = 0; pr = 0; pl = 0; pi = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                zpend = 2'b00;
                pv = 0;
            end else begin
                exp_done = zpend;
                zpend = 2'b00;
                if (pv && !pr) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd || out_id !== pi || out_last !== pl) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%0b d=%02h id=%0b l=%0b want v=1 d=%02h id=%0b l=%0b",
                                 out_valid, out_data, out_id, out_last, pd, pi, pl);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL stream_extra: got beat d=%02h id=%0b, want none", out_data, out_id);
                    end else begin
                        e = q.pop_front();
                        if ({out_id, out_last, out_data} !== {e.id, e.last, e.data}) begin
                            fails++;
                            $display("FAIL stream_beat: got id=%0b l=%0b d=%02h want id=%0b l=%0b d=%02h",
                                     out_id, out_last, out_data, e.id, e.last, e.data);
                        end
                        if (e.last) exp_done = exp_done | (2'b01 << e.id);
                    end
                end
                checks++;
                if (done !== exp_done) begin
                    fails++;
                    $display("FAIL done_pulse: got %b want %b", done, exp_done);
                end
                checks++;
                if ((req_ready & ~req_valid) != 2'b00 || !$onehot0(req_ready)) begin
                    fails++;
                    $display("FAIL ready_legal: got ready=%b valid=%b want onehot0 subset", req_ready, req_valid);
                end
                acc = req_valid & req_ready;
                if (acc != 2'b00) begin
                    aid   = acc[1] ? 1 : 0;
                    abase = int'(req_base[aid*AW +: AW]);
                    alen  = int'(req_len[aid*LEN_W +: LEN_W]);
                    if (alen == 0) zpend = 2'b01 << aid;
                    for (int k = 0; k < alen; k++)
                        q.push_back('{id: aid[0], last: (k == alen - 1), data: mem[(abase + k) % DEPTH]});
                end
                pv = out_valid; pr = out_ready; pd = out_data; pi = out_id; pl = out_last;
            end
        end
    endtask

    task automatic set_req(input int id, input int b, input int l);
        req_base[id*AW +: AW]     = AW'(b);
        req_len[id*LEN_W +: LEN_W] = LEN_W'(l);
        req_valid[id]             = 1'b1;
    endtask

    // Returns at the negedge where the request is visibly granted.
    task automatic wait_accept(input int id);
        int ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: got no ready for req%0d, want ready", id);
        end
    endtask

    task automatic wait_done(input int id);
        int ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done[id]) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL done_timeout: got no done for req%0d, want done", id);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, out_valid, out_data, out_id, out_last, done, busy, rom_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b v=%b d=%02h id=%b l=%b done=%b busy=%b addr=%03h want all 0",
                     req_ready, out_valid, out_data, out_id, out_last, done, busy, rom_addr);
        end
        req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_burst_addr(input int id, input int b, input int l);
        int ea;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_req(id, b, l);
        wait_accept(id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (int k = 0; k < l; k++) begin
            ea = (b + k) % DEPTH;
            checks++;
            if (rom_addr !== AW'(ea)) begin
                fails++;
                $display("FAIL burst_addr: got %03h want %03h (k=%0d)", rom_addr, ea, k);
            end
            checks++;
            if (out_valid !== (k >= 2)) begin
                fails++;
                $display("FAIL first_latency: got valid=%b want %b (T+%0d)", out_valid, (k >= 2), k);
            end
            @(posedge clk); #1;
        end
        wait_done(id);
    endtask

    task automatic test_round_robin();
        int p, expg, got;
        pulse_reset();
        out_ready = 1'b1;
        set_req(0, $urandom_range(0, DEPTH - 1), 2);
        set_req(1, $urandom_range(0, DEPTH - 1), 2);
        p = 0;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin got = 1; break; end
            end
            expg = req_valid[p] ? p : 1 - p;
            checks++;
            if (!got || req_ready !== (2'b01 << expg)) begin
                fails++;
                $display("FAIL rr_grant: got %b want %b (grant %0d)", req_ready, 2'b01 << expg, g);
            end
            p = 1 - expg;
        end
        @(posedge clk); #1 req_valid = 2'b00;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL rr_drain: got busy=%b valid=%b want idle", busy, out_valid);
        end
    endtask

    task automatic test_stall();
        int b, consumed, issued, fin;
        b = $urandom_range(0, DEPTH - 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_req(0, b, 8);
        wait_accept(0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        consumed = 0; fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            issued = int'(AW'(rom_addr - AW'(b)));
            checks++;
            if (issued - consumed > 2) begin
                fails++;
                $display("FAIL buffer_depth: got %0d pending bytes want <=2", issued - consumed);
            end
            if (out_valid && out_ready) consumed++;
            if (done[0]) fin = 1;
            else begin @(posedge clk); #1 out_ready = $urandom_range(0, 1); end
        end
        checks++;
        if (!fin || consumed !== 8) begin
            fails++;
            $display("FAIL stall_count: got %0d beats done=%0d want 8 done=1", consumed, fin);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_zero_len();
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_req(1, 5, 0);
        wait_accept(1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 2'b10 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_len: got done=%b busy=%b valid=%b want 10 0 0", done, busy, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || done !== 2'b00) begin
                fails++;
                $display("FAIL zero_len_quiet: got valid=%b done=%b want 0 00", out_valid, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_req(0, $urandom_range(0, DEPTH - 1), 10);
        wait_accept(0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        for (int i = 0; i < 100 && beats < 3; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) beats++;
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, out_valid, out_data, out_id, out_last, done, busy, rom_addr} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got v=%b d=%02h l=%b done=%b busy=%b addr=%03h want all 0",
                     out_valid, out_data, out_last, done, busy, rom_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 2'b00 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_hold: got done=%b valid=%b want 00 0", done, out_valid);
        end
        rst = 1'b0;
        set_req(0, $urandom_range(0, DEPTH - 1), 1);
        wait_accept(0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_done(0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        fork
            mon_loop();
        join_none
        test_reset();
        test_burst_addr(0, 'h010, 4);
        test_burst_addr(0, 'h3FE, 4);
        test_round_robin();
        test_stall();
        test_zero_len();
        test_reset_mid();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/weight_fetch_arb.md
WEIGHT_FETCH_ARB -- requirements
Module: weight_fetch_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of bytes in the shared weight ROM; AW = $clog2(DEPTH) is derived.
REQ-002 SHALL have parameter LEN_W, default 16, the width of the burst-length fields.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 2 bits: burst request valid, bit i for requester i.
REQ-006 SHALL have port req_ready_o, output, 2 bits: burst request accepted, bit i for requester i.
REQ-007 SHALL have port req_base_i, input, 2*AW bits: start byte address, slice [i*AW +: AW].
REQ-008 SHALL have port req_len_i, input, 2*LEN_W bits: burst length in bytes, slice [i*LEN_W +: LEN_W].
REQ-009 SHALL have port rom_addr_o, output, AW bits: address to the synchronous ROM; data returns one cycle later.
REQ-010 SHALL have port rom_data_i, input, 8 bits: ROM read data.
REQ-011 SHALL have port out_valid_o, output, 1 bit: byte stream valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: byte stream ready.
REQ-013 SHALL have port out_data_o, output, 8 bits: streamed byte.
REQ-014 SHALL have port out_id_o, output, 1 bit: index of the requester that owns the current byte.
REQ-015 SHALL have port out_last_o, output, 1 bit: marks the final byte of a burst.
REQ-016 SHALL have port done_o, output, 2 bits: one-cycle completion pulse per requester.
REQ-017 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE and FETCH.
- IDLE->FETCH on acceptance with len>0.
- FETCH->IDLE on the out_last handshake edge.
REQ-019 SHALL grant requesters round-robin.
- Grant is combinational in IDLE, to the valid requester at the priority pointer, else to the other.
- After a grant, the pointer moves to the non-granted requester.
- The pointer is 0 after reset.
REQ-020 SHALL assert req_ready_o only in IDLE, only for the granted requester, and never while rst_i is high; at most one bit is set per cycle.
REQ-021 SHALL, on acceptance, latch base, len and id, and load the address register with base at that edge.
REQ-022 SHALL issue one ROM read per cycle while FETCH and remaining reads > 0 and (fifo_count + inflight < 2, or an output handshake occurs in that cycle).
- The address increments by 1 per issued read.
- The address wraps from DEPTH-1 to 0.
REQ-023 SHALL write the returned rom_data_i into a 2-entry output FIFO exactly one cycle after each issued read; the FIFO never overflows.
REQ-024 SHALL drive the stream from the FIFO head.
- out_valid_o = FIFO non-empty.
- out_data_o/out_id_o/out_last_o stay stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL give first-byte latency of 2 cycles: if acceptance is at edge T, out_valid_o rises after edge T+2.
REQ-026 SHALL sustain 1 byte/cycle while out_ready_i is held high.
REQ-027 SHALL assert out_last_o only on byte number len of the burst (counting from 1).
REQ-028 SHALL pulse done_o[id] for one cycle, coincident with the out_last handshake cycle.
REQ-029 SHALL handle len=0 as follows:
- the request is accepted;
- no ROM reads and no stream beats occur;
- the FSM stays IDLE;
- done_o[id] pulses in the cycle after acceptance.
REQ-030 SHALL allow the next acceptance no earlier than the cycle after the FSM returns to IDLE.
REQ-031 SHALL let a requester keep req_valid_i asserted while waiting; waiting requests are neither dropped nor reordered.
REQ-032 SHALL count with remaining/issued counters of LEN_W bits; len up to 2^LEN_W-1 is supported.

Reset
REQ-033 SHALL, while rst_i is high, asynchronously force:
- state IDLE, pointer 0, FIFO empty, inflight 0;
- rom_addr_o=0, out_valid_o=0, out_data_o=0, out_id_o=0, out_last_o=0, done_o=0, busy_o=0, req_ready_o=0.
REQ-034 SHALL discard all in-flight and buffered bytes on reset mid-burst, with no done_o pulse; operation resumes on the first edge after rst_i falls.

Verification
REQ-035 Bench SHALL cover: req0 base=0x010 len=4, out_ready=1 -> rom_addr 0x010..0x013 on consecutive cycles; bytes mem[0x10..0x13] with first out_valid at T+2; out_last and done_o=01 on the 4th beat.
REQ-036 Bench SHALL cover: both requesters valid continuously with len=2 -> grants alternate 0,1,0,1; out_id matches the granted requester; every burst has exactly 2 beats.
REQ-037 Bench SHALL cover: DEPTH=1024, base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-038 Bench SHALL cover: len=8 with out_ready toggling randomly -> no byte lost or duplicated; outputs stable while stalled; no more than 2 bytes are buffered.
REQ-039 Bench SHALL cover: req1 len=0 -> accepted; done_o=10 pulses one cycle later; out_valid stays 0.
REQ-040 Bench SHALL cover: rst_i asserted after the 3rd beat of a len=10 burst -> outputs zero immediately with no done_o; a new req0 len=1 completes normally.
